// File: rtl/issue_queue_pkg.sv
// Shared definitions for the issue queue: the queue entry type and default depth.
package issue_queue_pkg;

  localparam int unsigned IQ_DEPTH_DEFAULT = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ISSUE_QUEUE_ELEMENT;

endpackage

// File: rtl/issue_queue.sv
// Two-wide in-order issue queue: circular buffer with up to two pushes and two pops per cycle.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int unsigned IQ_DEPTH = IQ_DEPTH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flash,
  input  logic                         stall,
  input  logic [1:0]                   push_number,
  input  ISSUE_QUEUE_ELEMENT [1:0]     push_data,
  output logic                         push_ready,
  input  logic [1:0]                   iq_pop_number,
  output ISSUE_QUEUE_ELEMENT [1:0]     issue_require,
  output logic [1:0]                   iq_size
);

  localparam int unsigned PW = $clog2(IQ_DEPTH);

  logic [PW-1:0]      head;
  logic [PW-1:0]      tail;
  logic [PW:0]        count;
  logic [PW-1:0]      head_next1;
  logic [PW-1:0]      tail_next1;
  logic [1:0]         push_acc;
  logic [1:0]         pop_eff;
  ISSUE_QUEUE_ELEMENT mem [IQ_DEPTH];

  // Readiness depends only on registered count so decode never waits on issue.
  assign push_ready = (count <= (PW+1)'(IQ_DEPTH - 2));
  assign head_next1 = head + PW'(1);
  assign tail_next1 = tail + PW'(1);

  always_comb begin
    push_acc = 2'd0;
    if (push_ready && push_number != 2'd3)
      push_acc = push_number;
  end

  always_comb begin
    pop_eff = 2'd0;
    if (!stall) begin
      if ((PW+1)'(iq_pop_number) > count)
        pop_eff = count[1:0];
      else
        pop_eff = iq_pop_number;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flash) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop_eff);
      tail  <= tail + PW'(push_acc);
      count <= count + (PW+1)'(push_acc) - (PW+1)'(pop_eff);
    end
  end

  // Storage is deliberately not reset; it is only visible while count covers it.
  always_ff @(posedge clk) begin
    if (!rst && !flash) begin
      if (push_acc != 2'd0)
        mem[tail] <= push_data[0];
      if (push_acc == 2'd2)
        mem[tail_next1] <= push_data[1];
    end
  end

  always_comb begin
    issue_require = '0;
    if (count >= (PW+1)'(1))
      issue_require[0] = mem[head];
    if (count >= (PW+1)'(2))
      issue_require[1] = mem[head_next1];
  end

  assign iq_size = (count >= (PW+1)'(2)) ? 2'd2 : count[1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (stall || ((PW+1)'(iq_pop_number) <= count))
        else $warning("issue_queue: iq_pop_number exceeds occupancy");
      assert (push_number != 2'd3)
        else $warning("issue_queue: push_number of 3 offered");
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Directed scoreboard bench for issue_queue: each stimulus step queues its expected outputs.
module tb_issue_queue;
  import issue_queue_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     flash;
  logic                     stall;
  logic [1:0]               push_number;
  ISSUE_QUEUE_ELEMENT [1:0] push_data;
  logic                     push_ready;
  logic [1:0]               iq_pop_number;
  ISSUE_QUEUE_ELEMENT [1:0] issue_require;
  logic [1:0]               iq_size;

  typedef struct {
    string        name;
    logic [130:0] exp;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  issue_queue #(.IQ_DEPTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .flash        (flash),
    .stall        (stall),
    .push_number  (push_number),
    .push_data    (push_data),
    .push_ready   (push_ready),
    .iq_pop_number(iq_pop_number),
    .issue_require(issue_require),
    .iq_size      (iq_size)
  );

  always #5 clk = ~clk;

  function automatic ISSUE_QUEUE_ELEMENT mk(input int n);
    ISSUE_QUEUE_ELEMENT e;
    if (n == 0) e = '0;
    else begin
      e.pc    = 32'h0000_1000 + 32'(n) * 32'd4;
      e.instr = 32'hA000_0000 + 32'(n);
    end
    return e;
  endfunction

  // One clock of stimulus; e0/e1 are expected entry tags after the edge (0 = all-zero).
  task automatic step(input string name, input bit r, input bit fl, input bit st,
                      input int pn, input int d0, input int d1, input int pop,
                      input int e0, input int e1, input int esize, input bit eready);
    exp_t x;
    rst           = r;
    flash         = fl;
    stall         = st;
    push_number   = 2'(pn);
    push_data[0]  = mk(d0);
    push_data[1]  = mk(d1);
    iq_pop_number = 2'(pop);
    @(posedge clk);
    #1;
    x.name = name;
    x.exp  = {mk(e0), mk(e1), 2'(esize), eready};
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t x;
      logic [130:0] act;
      x   = sb.pop_front();
      act = {issue_require[0], issue_require[1], iq_size, push_ready};
      vectors++;
      if (act !== x.exp) begin
        miscompares++;
        $display("FAIL %s: got req0=%h req1=%h size=%0d ready=%0b, expected req0=%h req1=%h size=%0d ready=%0b",
                 x.name, act[130:67], act[66:3], act[2:1], act[0],
                 x.exp[130:67], x.exp[66:3], x.exp[2:1], x.exp[0]);
      end
    end
  end

  initial begin
    //      name          rst fl st pn d0 d1 pop  e0 e1 sz rdy
    step("reset",          1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1);
    step("push_ab",        0, 0, 0, 2, 1, 2, 0,   1, 2, 2, 1);
    step("pop2_empty",     0, 0, 0, 0, 0, 0, 2,   0, 0, 0, 1);
    step("fill_2",         0, 0, 0, 2, 3, 4, 0,   3, 4, 2, 1);
    step("fill_4",         0, 0, 0, 2, 5, 6, 0,   3, 4, 2, 1);
    step("fill_6",         0, 0, 0, 2, 7, 8, 0,   3, 4, 2, 1);
    step("fill_7",         0, 0, 0, 1, 9, 0, 0,   3, 4, 2, 0);
    step("push_refused",   0, 0, 0, 2, 10, 11, 0, 3, 4, 2, 0);
    step("pop1_ready",     0, 0, 0, 0, 0, 0, 1,   4, 5, 2, 1);
    step("drain_a",        0, 0, 0, 0, 0, 0, 2,   6, 7, 2, 1);
    step("drain_b",        0, 0, 0, 0, 0, 0, 2,   8, 9, 2, 1);
    step("drain_c",        0, 0, 0, 0, 0, 0, 2,   0, 0, 0, 1);
    step("walk_push_a",    0, 0, 0, 2, 12, 13, 0, 12, 13, 2, 1);
    step("walk_pop_a",     0, 0, 0, 0, 0, 0, 2,   0, 0, 0, 1);
    step("walk_push_b",    0, 0, 0, 2, 14, 15, 0, 14, 15, 2, 1);
    step("walk_pop_b",     0, 0, 0, 0, 0, 0, 2,   0, 0, 0, 1);
    step("walk_push_c",    0, 0, 0, 2, 16, 17, 0, 16, 17, 2, 1);
    step("walk_pop_c",     0, 0, 0, 0, 0, 0, 2,   0, 0, 0, 1);
    step("wrap_push",      0, 0, 0, 2, 18, 19, 0, 18, 19, 2, 1);
    step("wrap_push_pop",  0, 0, 0, 2, 20, 21, 2, 20, 21, 2, 1);
    step("wrap_drain",     0, 0, 0, 0, 0, 0, 2,   0, 0, 0, 1);
    step("one_entry",      0, 0, 0, 1, 22, 0, 0,  22, 0, 1, 1);
    step("over_pop",       0, 0, 0, 0, 0, 0, 2,   0, 0, 0, 1);
    step("after_over",     0, 0, 0, 2, 23, 24, 0, 23, 24, 2, 1);
    step("count3",         0, 0, 0, 1, 25, 0, 0,  23, 24, 2, 1);
    step("stall_push",     0, 0, 1, 2, 26, 27, 2, 23, 24, 2, 1);
    step("stall_drain_a",  0, 0, 0, 0, 0, 0, 2,   25, 26, 2, 1);
    step("stall_drain_b",  0, 0, 0, 0, 0, 0, 2,   27, 0, 1, 1);
    step("stall_drain_c",  0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 1);
    step("pre_flash_a",    0, 0, 0, 2, 28, 29, 0, 28, 29, 2, 1);
    step("pre_flash_b",    0, 0, 0, 2, 30, 31, 0, 28, 29, 2, 1);
    step("flash",          0, 1, 1, 2, 32, 33, 1, 0, 0, 0, 1);
    step("post_flash",     0, 0, 0, 2, 34, 35, 0, 34, 35, 2, 1);
    step("rst_flash",      1, 1, 0, 2, 36, 37, 1, 0, 0, 0, 1);
    step("post_rst",       0, 0, 0, 1, 38, 0, 0,  38, 0, 1, 1);
    step("post_rst_b",     0, 0, 0, 2, 39, 40, 0, 38, 39, 2, 1);
    step("mid_rst",        1, 0, 0, 2, 41, 42, 1, 0, 0, 0, 1);
    step("idle",           0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1);
    repeat (3) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
